// File: rtl/mips_memsys_pkg.sv
// rtl/mips_memsys_pkg.sv - MMIO map, TXSTAT layout and status packing for mips_memsys.
package mips_memsys_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;
    localparam logic [7:0]  OFF_TXDATA = 8'h00;
    localparam logic [7:0]  OFF_TXSTAT = 8'h04;
    localparam logic [7:0]  OFF_CYCLE  = 8'h08;

    localparam int TXSTAT_EMPTY_BIT = 0;
    localparam int TXSTAT_FULL_BIT  = 1;
    localparam int TXSTAT_OVF_BIT   = 2;
    localparam int TXSTAT_CNT_LSB   = 8;
    localparam int TXSTAT_CNT_MSB   = 15;

    function automatic logic [31:0] pack_txstat(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] s;
        s = '0;
        s[TXSTAT_CNT_MSB:TXSTAT_CNT_LSB] = count;
        s[TXSTAT_OVF_BIT]                = ovf;
        s[TXSTAT_FULL_BIT]               = full;
        s[TXSTAT_EMPTY_BIT]              = empty;
        return s;
    endfunction

endpackage

// File: rtl/mips_tx_fifo.sv
// rtl/mips_tx_fifo.sv - Circular-buffer TX FIFO, no fall-through; push while full succeeds only with a pop.
module mips_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mips_memsys.sv
// rtl/mips_memsys.sv - MIPS unified RAM + MMIO (TX FIFO, cycle counter); counter gated by MIPS_MEMSYS_CYCLE_CTR_EN.
module mips_memsys
    import mips_memsys_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int IW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [IW-1:0] ram_idx;
    logic          is_mmio;
    logic [7:0]    reg_off;
    logic          wr_txdata, wr_txstat, wr_cycle;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_val;
    logic          unused_bits;

    assign is_mmio   = (adr[31:8] == MMIO_BASE[31:8]);
    assign reg_off   = {adr[7:2], 2'b00};
    assign ram_idx   = adr[IW+1:2];
    assign wr_txdata = memwrite && is_mmio && (reg_off == OFF_TXDATA);
    assign wr_txstat = memwrite && is_mmio && (reg_off == OFF_TXSTAT);
    assign wr_cycle  = memwrite && is_mmio && (reg_off == OFF_CYCLE);

    assign fifo_push = wr_txdata && !reset;
    assign fifo_pop  = tx_ready && !reset;

    mips_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (writedata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 32'b0 : fifo_head;

    // A push into a full FIFO is only lost when no pop frees a slot that edge.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_txstat)
            ovf_d = 1'b0;
        else if (fifo_push && fifo_full && !(fifo_pop && !fifo_empty))
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

`ifdef MIPS_MEMSYS_CYCLE_CTR_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (wr_cycle) cyc_d = writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign cycle_val = cyc_q;
`else
    logic unused_cycle;
    assign unused_cycle = wr_cycle;
    assign cycle_val    = 32'b0;
`endif

    // RAM is deliberately outside reset so stores during reset still land.
    always_ff @(posedge clk) begin
        if (memwrite && !is_mmio) ram_q[ram_idx] <= writedata;
    end

    always_comb begin
        readdata = 32'b0;
        if (!is_mmio) begin
            readdata = ram_q[ram_idx];
        end else begin
            case (reg_off)
                OFF_TXSTAT: readdata = pack_txstat(8'(fifo_count), ovf_q, fifo_full, fifo_empty);
                OFF_CYCLE:  readdata = cycle_val;
                default:    readdata = 32'b0;
            endcase
        end
    end

    assign unused_bits = ^{adr[1:0], fifo_count};

endmodule

// File: doc/mips_memsys.md
# mips_memsys

Unified memory responder on the multicycle MIPS memory port: services the core's `adr`/`writedata`/`memwrite` requests and drives `readdata` back. It contains word RAM for instructions and data, plus a small memory-mapped I/O window. The window holds a transmit FIFO that drains over a valid/ready stream and a free-running cycle counter. It sits beside `mips` at top level, replacing the bench-only memory model.

## Interface
Parameters:
- `RAM_WORDS`, 64: RAM depth in 32-bit words; power of two, ≥ 4.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..256.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `adr`  in  32  byte address from core.
- `writedata`  in  32  store data from core.
- `memwrite`  in  1  store strobe; write happens at the rising edge while high.
- `readdata`  out  32  combinational read data for `adr`.
- `tx_data`  out  32  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts head this cycle.

## Operation
Address decode: `adr[1:0]` is ignored (word accesses only).
- `adr[31:8] != 24'hFFFFFF`: RAM access. Index is `adr[$clog2(RAM_WORDS)+1:2]`, so higher addresses alias (wrap modulo depth).
- `0xFFFFFF00` TXDATA:
  - Write pushes `writedata` into the FIFO.
  - Read returns 0.
- `0xFFFFFF04` TXSTAT:
  - Read returns `{16'b0, count[7:0], 5'b0, ovf, full, empty}`.
  - Any write clears `ovf`.
- `0xFFFFFF08` CYCLE:
  - Read returns the counter.
  - Write loads `writedata` into it.
- Other `0xFFFFFFxx` addresses: read returns 0, write is ignored.

RAM:
- Reads are combinational from `adr`; the core latches `readdata` at the clock edge.
- Writes commit at the edge when `memwrite`=1.
- A read of the address being written in the same cycle returns the old word.
- RAM contents are not affected by reset.

TX FIFO:
- Push: TXDATA write and `!full`.
- Push while full (and no pop that cycle): word dropped, `ovf` set (sticky).
- Pop: `tx_valid && tx_ready`.
- Push and pop in the same cycle: both happen and count is unchanged. This applies even when full; the push is accepted and `ovf` is not set.
- No fall-through: a word pushed into an empty FIFO appears on `tx_valid`/`tx_data` the next cycle.
- `tx_data` is the head word when `tx_valid`, else 32'b0.
- `tx_data` must hold stable while `tx_valid && !tx_ready`.

Cycle counter:
- Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- A CYCLE write sets the next value to `writedata`, not `writedata+1`.

## Timing
- Read latency 0 cycles (combinational path `adr` → `readdata`); write latency 1 edge.
- State after a reset edge:
  - FIFO empty, count 0, `ovf` 0.
  - Cycle counter 0.
  - `tx_valid` 0, `tx_data` 0.
  - `readdata` follows `adr` combinationally, including during reset.
- During reset, stores and pops are suppressed. RAM writes with `memwrite`=1 still commit, because RAM is not reset.
- Reset mid-stream discards all FIFO contents. A sink holding `tx_ready` sees `tx_valid` fall on the edge where `reset` is sampled high.
- TXSTAT read reflects state before the current edge. A same-cycle push or pop is visible the next cycle.

## Configuration
- `MIPS_MEMSYS_CYCLE_CTR_EN` defined: cycle counter present, behaving as above.
- Macro not defined:
  - No counter register is synthesized.
  - CYCLE reads 0 and CYCLE writes are ignored.
  - All other behaviour is identical.

## Structure
- Package `mips_memsys_pkg` holds:
  - MMIO base `0xFFFFFF00` and register offsets (TXDATA 0x00, TXSTAT 0x04, CYCLE 0x08).
  - TXSTAT bit positions (empty 0, full 1, ovf 2, count 15:8).
- One sub-module, `mips_tx_fifo`:
  - Parameterized by depth and width.
  - Ports: push, push data, pop, head, count, full, empty.
  - Circular buffer with read and write pointers plus a count.
- Decode, RAM, `ovf` and counter stay in `mips_memsys`.

## Test plan
- RAM: store `0xDEADBEEF` at `0x10`, then read `0x10` → `0xDEADBEEF`. Read `0x10 + 4*RAM_WORDS` → same word (alias).
- FIFO order: `tx_ready`=0, push 1,2,3. TXSTAT reads count=3, empty=0. Raise `tx_ready` → `tx_data` 1,2,3 on consecutive cycles, then `tx_valid`=0.
- Overflow: `tx_ready`=0, push 9 words with depth 8. TXSTAT shows full=1, ovf=1, count=8; drained sequence is words 1..8. Writing TXSTAT clears ovf.
- Full with simultaneous pop: full FIFO, `tx_ready`=1 and a push in the same cycle. Count stays 8, ovf stays 0, and the pushed word emerges last.
- Counter: write CYCLE=`0xFFFFFFFE`, read on the next two cycles → `0xFFFFFFFE`, `0xFFFFFFFF`, then 0 (wrap). Without the macro, CYCLE reads 0.
- Reset mid-stream: 3 words queued, assert `reset` for one edge. `tx_valid`=0, TXSTAT = `0x00000001`, counter 0, and a previously stored RAM word is still readable.
